// File: rtl/fixp_pkg.sv
// Shared definitions for the fixed-point divider: default format, saturation limits, FSM states.
package fixp_pkg;

  localparam int FIXP_N = 16;
  localparam int FIXP_Q = 10;

  localparam logic [FIXP_N-1:0] FIXP_MAX = {1'b0, {(FIXP_N-1){1'b1}}};
  localparam logic [FIXP_N-1:0] FIXP_MIN = {1'b1, {(FIXP_N-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/fixp_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, subtract the divisor if it fits.
module fixp_div_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] rem_in,
  input  logic         div_bit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0] trial;

  // Trial subtraction; when it succeeds the difference is below 2^W, so the low W bits are exact.
  always_comb begin
    trial   = {rem_in, div_bit};
    q_bit   = 1'b0;
    rem_out = trial[W-1:0];
    if (trial >= {1'b0, divisor}) begin
      q_bit   = 1'b1;
      rem_out = trial[W-1:0] - divisor;
    end
  end

endmodule

// File: rtl/fixp_div.sv
// Iterative signed fixed-point divider (o_C = i_A / i_B), one quotient bit per clock,
// valid/ready handshakes on both sides, with saturation and divide-by-zero flagging.
module fixp_div
  import fixp_pkg::*;
#(
  parameter int N = FIXP_N,
  parameter int Q = FIXP_Q
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_A,
  input  logic [N-1:0] i_B,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_C,
  output logic         o_sat,
  output logic         o_div_by_zero
);

  localparam int            W         = N + Q;
  localparam int            CW        = $clog2(W);
  localparam logic [CW-1:0] LAST      = CW'(W - 1);
  localparam logic [N-1:0]  MAX_POS   = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  MIN_NEG   = {1'b1, {(N-1){1'b0}}};
  localparam logic [W-1:0]  POS_LIMIT = W'(MAX_POS);
  localparam logic [W-1:0]  NEG_LIMIT = W'(MIN_NEG);

  state_t        state, next_state;
  logic [CW-1:0] count;
  logic [W-1:0]  dividend;
  logic [W-1:0]  quot;
  logic [N-1:0]  rem;
  logic [N-1:0]  divisor;
  logic          sign;
  logic          a_neg;
  logic          dz;

  logic          accept;
  logic [N-1:0]  a_mag;
  logic [N-1:0]  b_mag;
  logic [N-1:0]  rem_next;
  logic          q_bit;
  logic [N-1:0]  fmt_c;
  logic          fmt_sat;

  // Magnitudes on N unsigned bits, so the most negative input maps cleanly to 2^(N-1).
  assign accept = i_valid & o_ready;
  assign a_mag  = i_A[N-1] ? (~i_A + 1'b1) : i_A;
  assign b_mag  = i_B[N-1] ? (~i_B + 1'b1) : i_B;

  fixp_div_step #(.W(N)) u_step (
    .rem_in  (rem),
    .div_bit (dividend[W-1]),
    .divisor (divisor),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic: accept, iterate W steps, format once, hold until downstream takes it.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept)        next_state = DIV;
      DIV:     if (count == LAST) next_state = FIX;
      FIX:                        next_state = DONE;
      DONE:    if (i_ready)       next_state = IDLE;
      default:                    next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; no overlap between operations.
  always_comb begin
    o_ready = (state == IDLE);
    o_valid = (state == DONE);
  end

  // Result formatting: divide-by-zero forcing, then sign-dependent saturation, else truncated quotient.
  always_comb begin
    fmt_c   = '0;
    fmt_sat = 1'b0;
    if (dz) begin
      fmt_c   = a_neg ? MIN_NEG : MAX_POS;
      fmt_sat = 1'b1;
    end else if (!sign) begin
      if (quot > POS_LIMIT) begin
        fmt_c   = MAX_POS;
        fmt_sat = 1'b1;
      end else begin
        fmt_c = quot[N-1:0];
      end
    end else begin
      if (quot > NEG_LIMIT) begin
        fmt_c   = MIN_NEG;
        fmt_sat = 1'b1;
      end else begin
        fmt_c = ~quot[N-1:0] + 1'b1;
      end
    end
  end

  // Datapath: latch operands on accept, shift one quotient bit per DIV cycle, register result in FIX.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count         <= '0;
      dividend      <= '0;
      quot          <= '0;
      rem           <= '0;
      divisor       <= '0;
      sign          <= 1'b0;
      a_neg         <= 1'b0;
      dz            <= 1'b0;
      o_C           <= '0;
      o_sat         <= 1'b0;
      o_div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sign     <= i_A[N-1] ^ i_B[N-1];
            a_neg    <= i_A[N-1];
            divisor  <= b_mag;
            dividend <= {a_mag, {Q{1'b0}}};
            rem      <= '0;
            quot     <= '0;
            count    <= '0;
            dz       <= (i_B == '0);
          end
        end
        DIV: begin
          rem      <= rem_next;
          quot     <= {quot[W-2:0], q_bit};
          dividend <= {dividend[W-2:0], 1'b0};
          count    <= count + 1'b1;
        end
        FIX: begin
          o_C           <= fmt_c;
          o_sat         <= fmt_sat;
          o_div_by_zero <= dz;
        end
        default: ;
      endcase
    end
  end

endmodule
